// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single physical-memory port between the instruction fetch unit (IF) and the
//   load/store unit (LS). One transaction in flight at a time, no pipelining.
//   LS has fixed priority. A starvation counter forces an IF grant after STARVE_MAX
//   consecutive LS grants made while IF was waiting.
//
// Parameters
//   MEM_LAT     memory read latency, mem_en cycle to valid mem_rdata (0..7)
//   STARVE_MAX  LS grants tolerated while IF waits before IF is forced (1..15)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr     IF request handshake and fetch address
//   if_rsp_valid, if_rsp_inst       IF response pulse and instruction word
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask      LS request handshake and access attributes
//   ls_rsp_valid, ls_rsp_rdata      LS response pulse and read data (0 for writes)
//   mem_en, mem_wen, mem_addr,
//   mem_wdata, mem_wmask            memory access strobe and attributes
//   mem_rdata                       memory read data
module pmem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_inst,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_addr,
    input  logic        ls_wen,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_rsp_valid,
    output logic [63:0] ls_rsp_rdata,

    output logic        mem_en,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam bit         LAT_ZERO   = (MEM_LAT == 0);
    localparam logic [2:0] LAT_M1     = LAT_ZERO ? 3'd0 : 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;

    logic        owner_ls_q;
    logic [63:0] addr_q;
    logic        wen_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic [31:0] if_inst_q;
    logic [63:0] ls_rdata_q;

    logic        idle;
    logic        if_forced;
    logic        if_grant;
    logic        ls_grant;
    logic        capture;

    // Gating with rst_n keeps the ready outputs low while reset is held.
    assign idle      = rst_n && (state_q == ST_IDLE);
    assign if_forced = (starve_q == STARVE_LIM);

    assign if_req_ready = idle && if_req_valid && (!ls_req_valid || if_forced);
    assign ls_req_ready = idle && ls_req_valid && !(if_req_valid && if_forced);
    assign if_grant     = if_req_ready;
    assign ls_grant     = ls_req_ready;

    // Read data is sampled exactly MEM_LAT cycles after the ISSUE cycle, i.e. in the last
    // cycle before RESP.
    assign capture = (LAT_ZERO && (state_q == ST_ISSUE)) ||
                     (!LAT_ZERO && (state_q == ST_WAIT) && (cnt_q == 3'd0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (if_grant || ls_grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = LAT_ZERO ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (idle) begin
            if (if_grant) begin
                starve_d = 4'd0;
            end else if (ls_grant && if_req_valid) begin
                starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
            end else if (!if_req_valid) begin
                starve_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Request latch, loaded on the accepting handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ls_q <= 1'b0;
            addr_q     <= 64'd0;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
        end else if (if_grant) begin
            owner_ls_q <= 1'b0;
            addr_q     <= if_addr;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
        end else if (ls_grant) begin
            owner_ls_q <= 1'b1;
            addr_q     <= ls_addr;
            wen_q      <= ls_wen;
            wdata_q    <= ls_wdata;
            wmask_q    <= ls_wmask;
        end
    end

    // Response data registers; they hold until the owner's next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_inst_q  <= 32'd0;
            ls_rdata_q <= 64'd0;
        end else if (capture) begin
            if (owner_ls_q) begin
                ls_rdata_q <= wen_q ? 64'd0 : mem_rdata;
            end else begin
                if_inst_q <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_wen   = mem_en && wen_q;
    assign mem_addr  = mem_en ? addr_q  : 64'd0;
    assign mem_wdata = mem_en ? wdata_q : 64'd0;
    assign mem_wmask = mem_en ? wmask_q : 8'd0;

    assign if_rsp_valid = (state_q == ST_RESP) && !owner_ls_q;
    assign ls_rsp_valid = (state_q == ST_RESP) && owner_ls_q;
    assign if_rsp_inst  = if_inst_q;
    assign ls_rsp_rdata = ls_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Randomised bench for pmem_arbiter. Three instances (MEM_LAT 0, 1, 3; STARVE_MAX 4, 4, 2)
//   each get their own random requesters and a memory whose read data changes every cycle.
//   A timeline reference model (accept cycle -> issue, response and next-free cycles)
//   predicts readiness, memory strobes and responses for every cycle.
module tb_pmem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int if_rate = 30;
    int ls_rate = 30;
    int wd_rate = 5;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory read data as a function of the cycle number.
    function automatic logic [63:0] mem_word(input int c);
        logic [31:0] u;
        u = 32'(c);
        return {(u * 32'h9E3779B1) ^ 32'hAAAABBBB, (u * 32'h85EBCA6B) ^ 32'hCCCCDDDD};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L  = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        localparam int SM = (g == 2) ? 2 : 4;

        logic        if_req_valid, if_req_ready, if_rsp_valid;
        logic [63:0] if_addr;
        logic [31:0] if_rsp_inst;
        logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
        logic [63:0] ls_addr, ls_wdata, ls_rsp_rdata;
        logic [7:0]  ls_wmask;
        logic        mem_en, mem_wen;
        logic [63:0] mem_addr, mem_wdata, mem_rdata;
        logic [7:0]  mem_wmask;

        pmem_arbiter #(
            .MEM_LAT   (L),
            .STARVE_MAX(SM)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .if_req_valid(if_req_valid),
            .if_req_ready(if_req_ready),
            .if_addr     (if_addr),
            .if_rsp_valid(if_rsp_valid),
            .if_rsp_inst (if_rsp_inst),
            .ls_req_valid(ls_req_valid),
            .ls_req_ready(ls_req_ready),
            .ls_addr     (ls_addr),
            .ls_wen      (ls_wen),
            .ls_wdata    (ls_wdata),
            .ls_wmask    (ls_wmask),
            .ls_rsp_valid(ls_rsp_valid),
            .ls_rsp_rdata(ls_rsp_rdata),
            .mem_en      (mem_en),
            .mem_wen     (mem_wen),
            .mem_addr    (mem_addr),
            .mem_wdata   (mem_wdata),
            .mem_wmask   (mem_wmask),
            .mem_rdata   (mem_rdata)
        );

        task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
            check($sformatf("L%0d_%s", L, t), got, exp);
        endtask

        initial begin : run
            int          n;
            int          next_free;
            int          issue_c;
            int          resp_c;
            int          starve;
            bit          live, idle, e_if_rdy, e_ls_rdy, hs_if, hs_ls;
            bit          own_ls, t_wen;
            logic [63:0] t_addr, t_wdata, rd;
            logic [7:0]  t_wmask;
            bit          if_pend, ls_pend;
            logic [63:0] if_a, ls_a, ls_d;
            logic        ls_w;
            logic [7:0]  ls_m;

            n = 0; next_free = 0; issue_c = -1; resp_c = -1; starve = 0;
            idle = 1'b0; own_ls = 1'b0; t_wen = 1'b0;
            t_addr = '0; t_wdata = '0; t_wmask = '0;
            if_pend = 1'b0; ls_pend = 1'b0;
            if_a = '0; ls_a = '0; ls_d = '0; ls_w = 1'b0; ls_m = '0;
            if_req_valid = 1'b0; if_addr = '0;
            ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
            mem_rdata = mem_word(0);

            forever begin
                @(negedge clk);
                live  = rst_n;
                hs_if = 1'b0;
                hs_ls = 1'b0;
                if (!live) begin
                    chk("rst_outs", 64'(|{if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_inst,
                                          ls_rsp_valid, ls_rsp_rdata, mem_en, mem_wen,
                                          mem_addr, mem_wdata, mem_wmask}), 64'd0);
                    next_free = 0; issue_c = -1; resp_c = -1; starve = 0;
                end else begin
                    idle     = (n >= next_free);
                    e_if_rdy = idle && if_req_valid && (!ls_req_valid || starve == SM);
                    e_ls_rdy = idle && ls_req_valid && !e_if_rdy;
                    chk("if_ready", 64'(if_req_ready), 64'(e_if_rdy));
                    chk("ls_ready", 64'(ls_req_ready), 64'(e_ls_rdy));
                    chk("both_ready", 64'(if_req_ready & ls_req_ready), 64'd0);
                    chk("mem_en", 64'(mem_en), 64'(n == issue_c));
                    if (n == issue_c) begin
                        chk("mem_addr", mem_addr, t_addr);
                        chk("mem_wen", 64'(mem_wen), 64'(t_wen));
                        chk("mem_wdata", mem_wdata, t_wdata);
                        chk("mem_wmask", 64'(mem_wmask), 64'(t_wmask));
                    end else begin
                        chk("mem_wen_idle", 64'(mem_wen), 64'd0);
                    end
                    chk("if_rsp_valid", 64'(if_rsp_valid), 64'(n == resp_c && !own_ls));
                    chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(n == resp_c && own_ls));
                    if (n == resp_c) begin
                        rd = mem_word(issue_c + L);
                        if (own_ls) begin
                            chk("ls_rdata", ls_rsp_rdata, t_wen ? 64'd0 : rd);
                        end else begin
                            chk("if_inst", {32'd0, if_rsp_inst},
                                t_addr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]});
                        end
                    end
                    hs_if = e_if_rdy;
                    hs_ls = e_ls_rdy;
                end

                @(posedge clk);
                if (live) begin
                    if (idle) begin
                        if (hs_if) starve = 0;
                        else if (hs_ls && if_req_valid) starve = (starve >= SM) ? SM : starve + 1;
                        else if (!if_req_valid) starve = 0;
                    end
                    if (hs_if) begin
                        own_ls = 1'b0; t_addr = if_a; t_wen = 1'b0; t_wdata = '0; t_wmask = '0;
                    end
                    if (hs_ls) begin
                        own_ls = 1'b1; t_addr = ls_a; t_wen = ls_w; t_wdata = ls_d; t_wmask = ls_m;
                    end
                    if (hs_if || hs_ls) begin
                        issue_c   = n + 1;
                        resp_c    = n + 2 + L;
                        next_free = n + 3 + L;
                    end
                end
                n++;

                #1;
                mem_rdata = mem_word(n);
                if (hs_if) if_pend = 1'b0;
                if (hs_ls) ls_pend = 1'b0;
                if (if_pend && $urandom_range(99) < wd_rate) begin
                    if_pend = 1'b0;
                end else if (!if_pend && $urandom_range(99) < if_rate) begin
                    if_pend = 1'b1;
                    if_a    = {$urandom, $urandom} & ~64'h3;
                end
                if (ls_pend && $urandom_range(99) < wd_rate) begin
                    ls_pend = 1'b0;
                end else if (!ls_pend && $urandom_range(99) < ls_rate) begin
                    ls_pend = 1'b1;
                    ls_a    = {$urandom, $urandom};
                    ls_w    = 1'($urandom_range(1));
                    ls_d    = {$urandom, $urandom};
                    ls_m    = 8'($urandom);
                end
                if_req_valid = if_pend;
                if_addr      = if_a;
                ls_req_valid = ls_pend;
                ls_addr      = ls_a;
                ls_wen       = ls_w;
                ls_wdata     = ls_d;
                ls_wmask     = ls_m;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // mixed traffic with occasional withdrawals
        repeat (800) @(posedge clk);

        // both requesters saturated: exercises the starvation guard
        if_rate = 100; ls_rate = 100; wd_rate = 0;
        repeat (600) @(posedge clk);

        // IF only, then LS only
        if_rate = 60; ls_rate = 0;
        repeat (300) @(posedge clk);
        if_rate = 0; ls_rate = 60;
        repeat (300) @(posedge clk);

        // busy traffic with asynchronous resets landing mid-transaction
        if_rate = 70; ls_rate = 70; wd_rate = 3;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(60, 20)) @(posedge clk);
            #2 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (200) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
